jt51_slot_seq: RTL
==================

Name: jt51_slot_seq

Overview:
- Slot scheduler for the operator accumulator and output stage.
- Runs the 32-slot operator round: four operator groups M1, M2, C1, C2, eight channels each.
- Generates the one-slot group-entry strobes and the op-31 noise strobe that sequence the accumulator.
- Captures the exact stereo sample once per round into a holding register with a valid/ready handshake towards the DAC/I2S consumer.

Parameters:
- ENTER_OFF, 0, slot offset (0..31) added to the raw counter before decoding strobes; aligns strobes with the operator pipeline depth.
- CAP_DLY, 1, cen-qualified cycles between the c1_enters slot and sample capture (1..3).

Ports:
- rst  in  1  asynchronous reset, active-high
- clk  in  1  system clock
- cen  in  1  clock enable; all state advances only when cen=1
- sync_clr  in  1  synchronous restart of the slot round, qualified by cen
- m1_enters  out  1  high during first slot of M1 group
- m2_enters  out  1  high during first slot of M2 group
- c1_enters  out  1  high during first slot of C1 group
- c2_enters  out  1  high during first slot of C2 group
- op31_acc  out  1  high during decoded slot 31
- cur_ch  out  3  channel index of decoded slot
- cur_op  out  2  operator group of decoded slot: 0=M1, 1=M2, 2=C1, 3=C2
- zero  out  1  high during decoded slot 0 (round start)
- xleft  in  16  signed exact left sample from accumulator
- xright  in  16  signed exact right sample from accumulator
- smp_left  out  16  held left sample
- smp_right  out  16  held right sample
- smp_valid  out  1  held sample pending
- smp_ready  in  1  consumer accepts the sample when smp_valid & smp_ready on a clk edge; not cen-qualified
- overrun  out  1  sticky: a sample was overwritten before acceptance
- ovr_clr  in  1  clears overrun

Behaviour:
- Reset values: slot counter=0; all strobe outputs reflect decoded slot (ENTER_OFF)&31; smp_left=smp_right=0; smp_valid=0; overrun=0; capture delay line cleared.
- Slot counter: 5-bit, increments on each cen, wraps 31->0.
- sync_clr with cen forces counter to 0 on that edge; also clears any in-flight capture delay. Does not touch the holding register.
- Decoded slot: d = (cnt + ENTER_OFF) mod 32.
  - cur_op = d[4:3]; cur_ch = d[2:0].
  - Group strobes: m1_enters when d==0, m2_enters when d==8, c1_enters when d==16, c2_enters when d==24.
  - op31_acc when d==31; zero when d==0.
- Strobes are registered outputs, exactly one cen period wide. Holding cen low holds every strobe at its current value.
- Capture: c1_enters arms a CAP_DLY-deep cen-qualified shift chain. On its output, xleft/xright load into smp_left/smp_right and smp_valid sets.
- Handshake, evaluated every clk edge:
  - Accept (valid&ready) clears smp_valid unless a capture occurs on the same edge. Simultaneous accept+capture loads new data and keeps valid=1 with no overrun.
  - Capture with valid=1 and ready=0: data overwritten, valid stays 1, overrun sets.
- overrun: cleared by ovr_clr. If ovr_clr and a set condition coincide, set wins.
- Mid-operation reset: asynchronous and immediate. Any pending sample is lost; valid=0.

Decomposition:
- Shared package constants: SLOTS=32, OP_M1=0, OP_M2=1, OP_C1=2, OP_C2=3, slot numbers of group starts (0, 8, 16, 24) and the noise slot (31).
- One natural sub-module: jt51_smp_hold, containing the holding register, valid/ready and overrun logic.
- Counter and strobe decode stay in the top.

Test Plan:
- Reset, ENTER_OFF=0, cen=1 constant:
  - m1/m2/c1/c2_enters pulse at cycles 0/8/16/24, op31_acc at 31.
  - Pattern repeats every 32 cycles; cur_ch cycles 0..7 in each group.
- ENTER_OFF=3: m1_enters first at counter 29; op31_acc at counter 28.
- cen asserted every 3rd clk: strobes stretch to 3 clks each and a round spans 96 clks. sync_clr at counter 13 gives zero on the next cen.
- Capture and accept: xleft=16'h7fff, xright=16'h8000 held, CAP_DLY=1, smp_ready=1.
  - smp_valid high for 1 clk starting one cen after c1_enters.
  - Samples match inputs; overrun stays 0.
- Overrun: smp_ready=0 for two rounds with xleft 100 then -200.
  - smp_left = -200, overrun=1.
  - ovr_clr pulse clears overrun; a coincident capture with valid=1 keeps overrun=1.
- Async rst asserted mid-round with smp_valid=1: outputs go to reset values without a clk edge. After release, m1_enters occurs at counter 0.

Source files
------------

// File: rtl/jt51_slot_seq_pkg.sv
// jt51_slot_seq_pkg
//   Shared constants, types and the slot decoder for the operator slot
//   scheduler. The round has 32 slots in four operator groups of eight
//   channels each: M1, M2, C1, C2.
package jt51_slot_seq_pkg;

    localparam int unsigned SLOTS = 32;

    typedef enum logic [1:0] {
        OP_M1 = 2'd0,
        OP_M2 = 2'd1,
        OP_C1 = 2'd2,
        OP_C2 = 2'd3
    } op_group_e;

    // First slot of each operator group, and the noise accumulation slot
    localparam logic [4:0] SLOT_M1    = 5'd0;
    localparam logic [4:0] SLOT_M2    = 5'd8;
    localparam logic [4:0] SLOT_C1    = 5'd16;
    localparam logic [4:0] SLOT_C2    = 5'd24;
    localparam logic [4:0] SLOT_NOISE = 5'd31;

    typedef struct packed {
        logic      m1;
        logic      m2;
        logic      c1;
        logic      c2;
        logic      op31;
        logic      zero;
        logic [2:0] ch;
        op_group_e  op;
    } slot_dec_t;

    function automatic slot_dec_t slot_decode(input logic [4:0] d);
        slot_dec_t r;
        r.m1   = (d == SLOT_M1);
        r.m2   = (d == SLOT_M2);
        r.c1   = (d == SLOT_C1);
        r.c2   = (d == SLOT_C2);
        r.op31 = (d == SLOT_NOISE);
        r.zero = (d == SLOT_M1);
        r.ch   = d[2:0];
        r.op   = op_group_e'(d[4:3]);
        return r;
    endfunction

endpackage

// File: rtl/jt51_slot_seq_smp_hold.sv
// jt51_smp_hold
//   Stereo sample holding register with a valid/ready handshake towards the
//   DAC/I2S consumer and a sticky overrun flag.
//   Ports:
//     clk_i, rst_i          clock, asynchronous active-high reset
//     cap_i                 one-clk capture pulse (already cen-qualified)
//     xleft_i, xright_i     samples loaded on capture
//     ready_i               consumer ready (evaluated every clk edge)
//     ovr_clr_i             clears overrun (a coincident set wins)
//     left_o, right_o       held samples
//     valid_o               held sample pending
//     ovr_o                 sticky overrun
module jt51_smp_hold (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cap_i,
    input  logic [15:0] xleft_i,
    input  logic [15:0] xright_i,
    input  logic        ready_i,
    input  logic        ovr_clr_i,
    output logic [15:0] left_o,
    output logic [15:0] right_o,
    output logic        valid_o,
    output logic        ovr_o
);

    logic [15:0] left_q, left_d;
    logic [15:0] right_q, right_d;
    logic        valid_q, valid_d;
    logic        ovr_q, ovr_d;

    always_comb begin
        left_d  = left_q;
        right_d = right_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (ovr_clr_i) ovr_d = 1'b0;
        if (cap_i) begin
            // A capture always leaves a pending sample; it only counts as an
            // overrun if the previous one is neither accepted now nor before.
            left_d  = xleft_i;
            right_d = xright_i;
            valid_d = 1'b1;
            if (valid_q && !ready_i) ovr_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            left_q  <= '0;
            right_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            left_q  <= left_d;
            right_q <= right_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign left_o  = left_q;
    assign right_o = right_q;
    assign valid_o = valid_q;
    assign ovr_o   = ovr_q;

endmodule

// File: rtl/jt51_slot_seq.sv
// jt51_slot_seq
//   Slot scheduler for the operator accumulator and output stage. Runs the
//   32-slot round, produces registered group-entry / noise / round-start
//   strobes and captures the stereo sample once per round.
//   Ports:
//     rst, clk, cen         async active-high reset, clock, clock enable
//     sync_clr              restart the round (cen-qualified)
//     m1/m2/c1/c2_enters    first slot of each operator group
//     op31_acc, zero        decoded slot 31 / slot 0
//     cur_ch, cur_op        channel and operator group of decoded slot
//     xleft, xright         exact samples from the accumulator
//     smp_left/right/valid  held sample and pending flag
//     smp_ready             consumer ready (not cen-qualified)
//     overrun, ovr_clr      sticky overwrite flag and its clear
module jt51_slot_seq
    import jt51_slot_seq_pkg::*;
#(
    parameter int unsigned ENTER_OFF = 0,
    parameter int unsigned CAP_DLY   = 1
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        sync_clr,
    output logic        m1_enters,
    output logic        m2_enters,
    output logic        c1_enters,
    output logic        c2_enters,
    output logic        op31_acc,
    output logic [2:0]  cur_ch,
    output logic [1:0]  cur_op,
    output logic        zero,
    input  logic [15:0] xleft,
    input  logic [15:0] xright,
    output logic [15:0] smp_left,
    output logic [15:0] smp_right,
    output logic        smp_valid,
    input  logic        smp_ready,
    output logic        overrun,
    input  logic        ovr_clr
);

    localparam int unsigned CW  = $clog2(SLOTS);
    localparam logic [CW-1:0] OFF = CW'(ENTER_OFF % SLOTS);

    logic [CW-1:0]      cnt_q, cnt_d;
    slot_dec_t          dec_q, dec_d;
    logic [CAP_DLY-1:0] chain_q, chain_d;
    logic               cap;

    // The strobes are decoded from the next counter value so they are
    // registered yet always describe the slot the counter currently holds.
    // Stage 0 of the delay chain is loaded alongside c1_enters, so the last
    // stage fires CAP_DLY cen periods after the c1 slot begins.
    always_comb begin
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        chain_d = chain_q;
        cap     = 1'b0;
        if (cen) begin
            cnt_d      = sync_clr ? '0 : cnt_q + 1'b1;
            dec_d      = slot_decode(cnt_d + OFF);
            cap        = chain_q[CAP_DLY-1] & ~sync_clr;
            chain_d[0] = dec_d.c1;
            for (int unsigned i = 1; i < CAP_DLY; i++) begin
                chain_d[i] = chain_q[i-1] & ~sync_clr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            dec_q   <= slot_decode(OFF);
            chain_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            chain_q <= chain_d;
        end
    end

    assign m1_enters = dec_q.m1;
    assign m2_enters = dec_q.m2;
    assign c1_enters = dec_q.c1;
    assign c2_enters = dec_q.c2;
    assign op31_acc  = dec_q.op31;
    assign zero      = dec_q.zero;
    assign cur_ch    = dec_q.ch;
    assign cur_op    = dec_q.op;

    jt51_smp_hold u_hold (
        .clk_i     (clk),
        .rst_i     (rst),
        .cap_i     (cap),
        .xleft_i   (xleft),
        .xright_i  (xright),
        .ready_i   (smp_ready),
        .ovr_clr_i (ovr_clr),
        .left_o    (smp_left),
        .right_o   (smp_right),
        .valid_o   (smp_valid),
        .ovr_o     (overrun)
    );

endmodule
